// File: rtl/fifo_ctrl_16to32.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_16to32
//
// Controller that turns a 128x16-write / 64x32-read two-port LSRAM into a
// width-converting FIFO.
//
// The digitizer sample packer pushes 16-bit halfwords into the FIFO.
// The readout engine pops 32-bit words from it.
// The first halfword written lands in the low half of a read word.
// No data passes through this block. It only sequences the RAM ports and
// keeps the occupancy bookkeeping.
//
// Ports
//   CLK         single clock, also feeds the RAM W_CLK / R_CLK
//   RESET       asynchronous active-high reset
//   FLUSH       synchronous clear of pointers, count and flags
//   WE          write request, one halfword per cycle
//   RE          read request, one 32-bit word per cycle
//   RAM_W_ADDR  RAM write address (halfwords)
//   RAM_W_EN    RAM write enable
//   RAM_R_ADDR  RAM read address (32-bit words)
//   RAM_R_EN    RAM read enable
//   DVLD        RAM R_DATA holds a newly read word this cycle
//   FULL        no room for another halfword
//   EMPTY       fewer than two halfwords readable
//   AFULL       CNT >= AFULL_TH
//   AEMPTY      CNT <= AEMPTY_TH
//   CNT         halfwords stored and not yet read (0..2**WADDR_W)
//   OVERFLOW    sticky, a write was rejected
//   UNDERFLOW   sticky, a read was rejected
//
// Build option
//   FIFO_CTRL_FWFT_EN  When defined, the block runs first-word-fall-through.
//                      A prefetch FSM keeps the head word on R_DATA, and
//                      EMPTY = !DVLD.
//                      When undefined, DVLD is a one-cycle pulse after each
//                      accepted read.
// ---------------------------------------------------------------------------
module fifo_ctrl_16to32 #(
  parameter int WADDR_W   = 7,
  parameter int RADDR_W   = 6,
  parameter int AFULL_TH  = 120,
  parameter int AEMPTY_TH = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               FLUSH,
  input  logic               WE,
  input  logic               RE,
  output logic [WADDR_W-1:0] RAM_W_ADDR,
  output logic               RAM_W_EN,
  output logic [RADDR_W-1:0] RAM_R_ADDR,
  output logic               RAM_R_EN,
  output logic               DVLD,
  output logic               FULL,
  output logic               EMPTY,
  output logic               AFULL,
  output logic               AEMPTY,
  output logic [WADDR_W:0]   CNT,
  output logic               OVERFLOW,
  output logic               UNDERFLOW
);

  localparam logic [WADDR_W:0] DEPTH_LV  = (WADDR_W+1)'(2**WADDR_W);
  localparam logic [WADDR_W:0] AFULL_LV  = (WADDR_W+1)'(AFULL_TH);
  localparam logic [WADDR_W:0] AEMPTY_LV = (WADDR_W+1)'(AEMPTY_TH);
  localparam logic [WADDR_W:0] CNT_TWO   = (WADDR_W+1)'(2);

  logic [WADDR_W:0] wptr_q, wptr_d;
  logic [RADDR_W:0] rptr_q, rptr_d;
  logic [WADDR_W:0] cnt_q, cnt_d;
  logic             dvld_q, dvld_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_ok;
  logic             rd_ok;

  // A write is accepted when the registered FULL flag is clear.
  // A read in the same cycle does not make room for it.
  // FLUSH suppresses the write.
  always_comb begin
    wr_ok = WE & ~full_q & ~FLUSH;
  end

`ifdef FIFO_CTRL_FWFT_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  fetch_state_e state_q, state_d;

  // Register the prefetch state.
  // The head word is valid in FETCH and HOLD.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Prefetch sequencing.
  // In IDLE, fetch as soon as a full word is stored.
  // While a head word is presented, RE consumes it. If another word is
  // available, it is fetched in the same cycle so DVLD has no bubble.
  always_comb begin
    state_d = state_q;
    rd_ok   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q >= CNT_TWO) begin
          rd_ok   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH, HOLD: begin
        if (RE) begin
          if (cnt_q >= CNT_TWO) begin
            rd_ok   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
    if (FLUSH) begin
      rd_ok   = 1'b0;
      state_d = IDLE;
    end
    dvld_d = (state_d != IDLE);
  end
`else
  // Standard mode.
  // A read is accepted when the registered EMPTY flag is clear.
  // DVLD follows one cycle later, when the RAM bypass output shows the word.
  always_comb begin
    rd_ok  = RE & ~empty_q & ~FLUSH;
    dvld_d = rd_ok;
  end
`endif

  // Next-state values for the pointers, count and flags.
  // The count is the pointer difference: write pointer minus twice the read
  // pointer. The extra wrap bit on each pointer separates a full FIFO from
  // an empty one.
  // Every flag is taken from the next count, so it is valid in the same
  // cycle as CNT.
  always_comb begin
    wptr_d = wptr_q + {{WADDR_W{1'b0}}, wr_ok};
    rptr_d = rptr_q + {{RADDR_W{1'b0}}, rd_ok};
    ovf_d  = ovf_q | (WE & full_q);
    unf_d  = unf_q | (RE & empty_q);
    if (FLUSH) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end
    cnt_d    = wptr_d - {rptr_d, 1'b0};
    full_d   = (cnt_d == DEPTH_LV);
    afull_d  = (cnt_d >= AFULL_LV);
    aempty_d = (cnt_d <= AEMPTY_LV);
`ifdef FIFO_CTRL_FWFT_EN
    empty_d  = ~dvld_d;
`else
    empty_d  = (cnt_d < CNT_TWO);
`endif
  end

  // State register.
  // Reset leaves the FIFO empty with both sticky error flags clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      dvld_q   <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      dvld_q   <= dvld_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // RAM strobes are combinational from this cycle's accept decision.
  // The addresses are the pointers without their wrap bits.
  always_comb begin
    RAM_W_EN   = wr_ok;
    RAM_W_ADDR = wptr_q[WADDR_W-1:0];
    RAM_R_EN   = rd_ok;
    RAM_R_ADDR = rptr_q[RADDR_W-1:0];
    DVLD       = dvld_q;
    FULL       = full_q;
    EMPTY      = empty_q;
    AFULL      = afull_q;
    AEMPTY     = aempty_q;
    CNT        = cnt_q;
    OVERFLOW   = ovf_q;
    UNDERFLOW  = unf_q;
  end

endmodule

// File: tb/tb_fifo_ctrl_16to32.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl_16to32
//
// Testbench for the default (standard-mode) build of fifo_ctrl_16to32.
//
// A small 128x16 / 64x32 RAM model sits on the controller's RAM ports.
// The reference is a halfword queue:
//   - an accepted read pops two halfwords and pushes the packed word
//     into a scoreboard;
//   - a monitor on the falling edge pops the scoreboard whenever DVLD is
//     high and compares the packed word with the RAM output.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl_16to32;

  localparam int WADDR_W = 7;
  localparam int RADDR_W = 6;

  logic               CLK = 1'b0;
  logic               RESET;
  logic               FLUSH;
  logic               WE;
  logic               RE;
  logic [WADDR_W-1:0] RAM_W_ADDR;
  logic               RAM_W_EN;
  logic [RADDR_W-1:0] RAM_R_ADDR;
  logic               RAM_R_EN;
  logic               DVLD;
  logic               FULL;
  logic               EMPTY;
  logic               AFULL;
  logic               AEMPTY;
  logic [WADDR_W:0]   CNT;
  logic               OVERFLOW;
  logic               UNDERFLOW;

  logic [15:0] wrData;
  logic [15:0] ramMem [0:127];
  logic [31:0] ramRData;

  logic [15:0] modelQ[$];
  logic [31:0] expQ[$];
  int          wrCount;
  int          rdCount;
  bit          modelOvf;
  bit          modelUnf;
  int          checks;
  int          errors;
  logic [31:0] expWord;

  fifo_ctrl_16to32 dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .FLUSH      (FLUSH),
    .WE         (WE),
    .RE         (RE),
    .RAM_W_ADDR (RAM_W_ADDR),
    .RAM_W_EN   (RAM_W_EN),
    .RAM_R_ADDR (RAM_R_ADDR),
    .RAM_R_EN   (RAM_R_EN),
    .DVLD       (DVLD),
    .FULL       (FULL),
    .EMPTY      (EMPTY),
    .AFULL      (AFULL),
    .AEMPTY     (AEMPTY),
    .CNT        (CNT),
    .OVERFLOW   (OVERFLOW),
    .UNDERFLOW  (UNDERFLOW)
  );

  // 10 ns clock.
  always #5 CLK = ~CLK;

  // Two-port LSRAM stand-in.
  // The read port latches a 32-bit word on R_EN and holds it until the
  // next read.
  always @(posedge CLK) begin
    if (RAM_W_EN) ramMem[RAM_W_ADDR] <= wrData;
    if (RAM_R_EN) ramRData <= {ramMem[{RAM_R_ADDR, 1'b1}], ramMem[{RAM_R_ADDR, 1'b0}]};
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare the registered status outputs with the occupancy of the
  // reference queue.
  task automatic checkStatus();
    int n;
    n = modelQ.size();
    checkOutput("cnt", 32'(CNT), n);
    checkOutput("full", 32'(FULL), 32'(n == 128));
    checkOutput("empty", 32'(EMPTY), 32'(n < 2));
    checkOutput("afull", 32'(AFULL), 32'(n >= 120));
    checkOutput("aempty", 32'(AEMPTY), 32'(n <= 4));
    checkOutput("overflow", 32'(OVERFLOW), 32'(modelOvf));
    checkOutput("underflow", 32'(UNDERFLOW), 32'(modelUnf));
  endtask

  task automatic clearModel();
    modelQ.delete();
    wrCount  = 0;
    rdCount  = 0;
    modelOvf = 1'b0;
    modelUnf = 1'b0;
  endtask

  // Run one clock cycle.
  // Entered and left 1 ns after a rising edge.
  // Drives the inputs, checks the strobes and status against the model,
  // then advances the model at the next edge.
  task automatic applyStimulus(input bit we, input bit re, input bit flush, input logic [15:0] data);
    bit          mFull;
    bit          mEmpty;
    bit          wrOk;
    bit          rdOk;
    logic [15:0] lo;
    logic [15:0] hi;
    WE     = we;
    RE     = re;
    FLUSH  = flush;
    wrData = data;
    #1;
    mFull  = (modelQ.size() == 128);
    mEmpty = (modelQ.size() < 2);
    wrOk   = we && !mFull && !flush;
    rdOk   = re && !mEmpty && !flush;
    checkOutput("ram_w_en", 32'(RAM_W_EN), 32'(wrOk));
    checkOutput("ram_r_en", 32'(RAM_R_EN), 32'(rdOk));
    if (wrOk) checkOutput("ram_w_addr", 32'(RAM_W_ADDR), wrCount % 128);
    if (rdOk) checkOutput("ram_r_addr", 32'(RAM_R_ADDR), rdCount % 64);
    checkStatus();
    @(posedge CLK);
    if (flush) begin
      clearModel();
    end else begin
      if (we && mFull) modelOvf = 1'b1;
      if (re && mEmpty) modelUnf = 1'b1;
      if (rdOk) begin
        lo = modelQ.pop_front();
        hi = modelQ.pop_front();
        expQ.push_back({hi, lo});
        rdCount++;
      end
      if (wrOk) begin
        modelQ.push_back(data);
        wrCount++;
      end
    end
    #1;
  endtask

  // Scoreboard monitor.
  // A word issued at a rising edge must show DVLD in the following low
  // phase, and the RAM output must match it.
  always @(negedge CLK) begin
    checkOutput("dvld_vs_scoreboard", 32'(DVLD), 32'(expQ.size() > 0));
    if (DVLD && expQ.size() > 0) begin
      expWord = expQ.pop_front();
      checkOutput("read_data", ramRData, expWord);
    end
  end

  // Directed cases first, then randomized traffic, then a mid-run reset.
  initial begin
    checks = 0;
    errors = 0;
    clearModel();
    RESET  = 1'b1;
    FLUSH  = 1'b0;
    WE     = 1'b0;
    RE     = 1'b0;
    wrData = '0;
    repeat (2) @(posedge CLK);
    #1;
    checkStatus();
    checkOutput("dvld_reset", 32'(DVLD), 32'd0);
    RESET = 1'b0;

    // Two halfwords, then one read of the packed word.
    applyStimulus(1, 0, 0, 16'h1111);
    applyStimulus(1, 0, 0, 16'h2222);
    applyStimulus(0, 1, 0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("pair_word", ramRData, 32'h22221111);

    // Fill to FULL, write once more, then drain and read once too often.
    for (int i = 0; i < 128; i++) applyStimulus(1, 0, 0, 16'($urandom));
    applyStimulus(1, 0, 0, 16'hDEAD);
    applyStimulus(0, 0, 0, 16'h0);
    for (int i = 0; i < 64; i++) applyStimulus(0, 1, 0, 16'h0);
    applyStimulus(0, 1, 0, 16'h0);
    applyStimulus(0, 0, 1, 16'h0);

    // Three fill/drain rounds with sequential data, so the pointers wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 128; i++) applyStimulus(1, 0, 0, 16'(r * 128 + i));
      for (int i = 0; i < 64; i++) applyStimulus(0, 1, 0, 16'h0);
    end
    applyStimulus(0, 0, 0, 16'h0);

    // A lone halfword blocks reads until its partner arrives.
    applyStimulus(1, 0, 0, 16'hAAAA);
    applyStimulus(0, 1, 0, 16'h0);
    applyStimulus(1, 0, 0, 16'hBBBB);
    applyStimulus(0, 1, 0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("odd_word", ramRData, 32'hBBBBAAAA);

    // FLUSH wins over simultaneous WE and RE at CNT = 64.
    for (int i = 0; i < 64; i++) applyStimulus(1, 0, 0, 16'($urandom));
    applyStimulus(1, 1, 1, 16'h5555);
    applyStimulus(0, 0, 0, 16'h0);

    // Randomized traffic in three phases: write-heavy, read-heavy, balanced.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 600; i++) begin
        int wBias;
        int rBias;
        wBias = (p == 0) ? 75 : (p == 1) ? 30 : 50;
        rBias = (p == 0) ? 30 : (p == 1) ? 75 : 50;
        applyStimulus($urandom_range(0, 99) < wBias, $urandom_range(0, 99) < rBias,
                      $urandom_range(0, 199) == 0, 16'($urandom));
      end
    end

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 10; i++) applyStimulus(1, i[0], 0, 16'($urandom));
    RESET = 1'b1;
    #1;
    clearModel();
    expQ.delete();
    checkStatus();
    checkOutput("dvld_mid_reset", 32'(DVLD), 32'd0);
    RESET = 1'b0;
    applyStimulus(0, 0, 0, 16'h0);
    applyStimulus(1, 0, 0, 16'h0F0F);
    applyStimulus(1, 0, 0, 16'hF0F0);
    applyStimulus(0, 1, 0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
